// File: rtl/mdbrot_scan_ctrl_if.sv
// Scanner <-> environment bundle: start/done, iteration-engine request/result, VGA plot port.
`timescale 1ns/1ps
interface mdbrot_scan_ctrl_if #(
  parameter int unsigned W = 16
);
  logic                start;
  logic                done;
  logic                eng_valid;
  logic                eng_ready;
  logic signed [W-1:0] eng_cr;
  logic signed [W-1:0] eng_ci;
  logic                res_valid;
  logic [7:0]          res_iter;
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [2:0]          vga_colour;
  logic                vga_plot;

  modport master (
    input  start, eng_ready, res_valid, res_iter,
    output done, eng_valid, eng_cr, eng_ci, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output start, eng_ready, res_valid, res_iter,
    input  done, eng_valid, eng_cr, eng_ci, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/mdbrot_scan_ctrl.sv
// Raster scanner for the 160x120 Mandelbrot plot: issues c per pixel, colours the result.
// Optional MDBROT_CLEAR_EN: blank the whole screen (colour 0) before each frame.
`timescale 1ns/1ps
module mdbrot_scan_ctrl #(
  parameter int unsigned W        = 16,
  parameter int          CR_START = -8192,
  parameter int          CI_START = 4096,
  parameter int          STEP_X   = 77,
  parameter int          STEP_Y   = 68,
  parameter logic [7:0]  MAX_ITER = 8'd255
) (
  input logic                clk_i,
  input logic                rst_i,
  mdbrot_scan_ctrl_if.master bus
);

  localparam logic [7:0]          XLast   = 8'd159;
  localparam logic [6:0]          YLast   = 7'd119;
  localparam logic signed [W-1:0] CrStart = W'(CR_START);
  localparam logic signed [W-1:0] CiStart = W'(CI_START);
  localparam logic signed [W-1:0] StepX   = W'(STEP_X);
  localparam logic signed [W-1:0] StepY   = W'(STEP_Y);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StWait,
    StPlot,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic signed [W-1:0] cr_q, cr_d;
  logic signed [W-1:0] ci_q, ci_d;
  logic [2:0]          colour_q, colour_d;

  // Escaped points are coloured by the low count bits; 0 is remapped so it never looks "in set".
  function automatic logic [2:0] iter_colour(input logic [7:0] iter);
    if (iter >= MAX_ITER) begin
      return 3'b000;
    end
    if (iter[2:0] == 3'b000) begin
      return 3'b111;
    end
    return iter[2:0];
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      cr_q     <= '0;
      ci_q     <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cr_q     <= cr_d;
      ci_q     <= ci_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cr_d     = cr_q;
    ci_d     = ci_q;
    colour_d = colour_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          x_d  = '0;
          y_d  = '0;
          cr_d = CrStart;
          ci_d = CiStart;
`ifdef MDBROT_CLEAR_EN
          colour_d = 3'b000;
          state_d  = StClear;
`else
          state_d  = StIssue;
`endif
        end
      end

`ifdef MDBROT_CLEAR_EN
      // One blank pixel per cycle; cr/ci already hold the frame origin for the first request.
      StClear: begin
        if (x_q == XLast) begin
          x_d = '0;
          if (y_q == YLast) begin
            y_d     = '0;
            cr_d    = CrStart;
            ci_d    = CiStart;
            state_d = StIssue;
          end else begin
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
`endif

      StIssue: begin
        if (bus.eng_ready) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (bus.res_valid) begin
          colour_d = iter_colour(bus.res_iter);
          state_d  = StPlot;
        end
      end

      StPlot: begin
        if (x_q == XLast) begin
          if (y_q == YLast) begin
            state_d = StDone;
          end else begin
            x_d     = '0;
            cr_d    = CrStart;
            y_d     = y_q + 7'd1;
            ci_d    = ci_q - StepY;
            state_d = StIssue;
          end
        end else begin
          x_d     = x_q + 8'd1;
          cr_d    = cr_q + StepX;
          state_d = StIssue;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.eng_valid  = (state_q == StIssue);
  assign bus.vga_plot   = (state_q == StPlot) || (state_q == StClear);
  assign bus.done       = (state_q == StDone);
  assign bus.eng_cr     = cr_q;
  assign bus.eng_ci     = ci_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;

endmodule

// File: tb/tb_mdbrot_scan_ctrl.sv
// Self-checking bench for mdbrot_scan_ctrl: stub engine with random handshakes vs raster model.
`timescale 1ns/1ps
module tb_mdbrot_scan_ctrl;

  localparam int W        = 16;
  localparam int CR_START = -8192;
  localparam int CI_START = 4096;
  localparam int STEP_X   = 77;
  localparam int STEP_Y   = 68;
  localparam int NPIX     = 160 * 120;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   plot_cnt = 0;
  int   frame_plot_base = 0;

  mdbrot_scan_ctrl_if #(.W(W)) bus ();

  mdbrot_scan_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.vga_plot === 1'b1) plot_cnt <= plot_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_colour(input int iter);
    if (iter >= 255) return 3'b000;
    if (iter % 8 == 0) return 3'b111;
    return 3'(iter % 8);
  endfunction

  // Serves pixel n in raster order. Entered on the negedge where the request should be visible.
  task automatic serve_pixel(input int n, input bit fast, input int stall, input int lat,
                             input int iter_in);
    int                  x, y, iter;
    logic signed [W-1:0] ecr, eci;
    logic [2:0]          ecol;
    bit                  rdy, acc;
    x    = n % 160;
    y    = n / 160;
    ecr  = W'(CR_START + x * STEP_X);
    eci  = W'(CI_START - y * STEP_Y);
    iter = (iter_in < 0) ? int'($urandom_range(0, 255)) : iter_in;
    ecol = ref_colour(iter);
    acc  = 1'b0;
    for (int c = 0; c < stall + 12 && !acc; c++) begin
      checks++;
      if (bus.eng_valid !== 1'b1 || bus.eng_cr !== ecr || bus.eng_ci !== eci ||
          bus.vga_x !== 8'(x) || bus.vga_y !== 7'(y) || bus.vga_plot !== 1'b0 ||
          bus.done !== 1'b0) begin
        errors++;
        $display("FAIL request[%0d]: valid=%b cr=%0d ci=%0d x=%0d y=%0d plot=%b done=%b, want 1 %0d %0d %0d %0d 0 0",
                 n, bus.eng_valid, bus.eng_cr, bus.eng_ci, bus.vga_x, bus.vga_y,
                 bus.vga_plot, bus.done, ecr, eci, x, y);
      end
      rdy = (c >= stall) && (fast || c >= stall + 10 || $urandom_range(0, 2) != 0);
      bus.eng_ready = rdy;
      // A stray result while the request is pending must be ignored.
      bus.res_valid = !rdy && ($urandom_range(0, 2) == 0);
      bus.res_iter  = 8'($urandom_range(0, 255));
      @(negedge clk);
      bus.eng_ready = 1'b0;
      bus.res_valid = 1'b0;
      acc = rdy;
    end
    for (int c = 1; c <= lat; c++) begin
      checks++;
      if (bus.eng_valid !== 1'b0 || bus.vga_plot !== 1'b0) begin
        errors++;
        $display("FAIL wait[%0d]: valid=%b plot=%b, want 0 0", n, bus.eng_valid, bus.vga_plot);
      end
      if (c == lat) begin
        bus.res_valid = 1'b1;
        bus.res_iter  = 8'(iter);
      end
      @(negedge clk);
    end
    bus.res_valid = 1'b0;
    checks++;
    if (bus.vga_plot !== 1'b1 || bus.vga_x !== 8'(x) || bus.vga_y !== 7'(y) ||
        bus.vga_colour !== ecol || bus.eng_valid !== 1'b0) begin
      errors++;
      $display("FAIL plot[%0d]: plot=%b x=%0d y=%0d colour=%0d valid=%b, want 1 %0d %0d %0d 0",
               n, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.eng_valid, x, y, ecol);
    end
    @(negedge clk);
    checks++;
    if (bus.vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL plot_width[%0d]: plot=%b, want 0", n, bus.vga_plot);
    end
  endtask

  task automatic check_clear(input int count);
    for (int i = 0; i < count; i++) begin
      checks++;
      if (bus.vga_plot !== 1'b1 || bus.eng_valid !== 1'b0 || bus.vga_x !== 8'(i % 160) ||
          bus.vga_y !== 7'(i / 160) || bus.vga_colour !== 3'b000) begin
        errors++;
        $display("FAIL clear[%0d]: plot=%b valid=%b x=%0d y=%0d colour=%0d, want 1 0 %0d %0d 0",
                 i, bus.vga_plot, bus.eng_valid, bus.vga_x, bus.vga_y, bus.vga_colour,
                 i % 160, i / 160);
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.done, bus.eng_valid, bus.eng_cr, bus.eng_ci, bus.vga_x, bus.vga_y,
         bus.vga_colour, bus.vga_plot} !== 53'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", {bus.done, bus.eng_valid, bus.eng_cr,
               bus.eng_ci, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (bus.eng_valid !== 1'b0 || bus.vga_plot !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: valid=%b plot=%b done=%b, want 0 0 0",
                 i, bus.eng_valid, bus.vga_plot, bus.done);
      end
    end
  endtask

  task automatic test_single_pixel();
    frame_plot_base = plot_cnt;
    pulse_start();
`ifdef MDBROT_CLEAR_EN
    check_clear(NPIX);
`endif
    checks++;
    if (bus.eng_cr !== 16'(CR_START) || bus.eng_ci !== 16'(CI_START)) begin
      errors++;
      $display("FAIL first_c: cr=%0d ci=%0d, want -8192 4096", bus.eng_cr, bus.eng_ci);
    end
    serve_pixel(0, 1'b1, 0, 2, 3);
  endtask

  task automatic test_backpressure();
    serve_pixel(1, 1'b1, 5, 3, -1);
  endtask

  task automatic test_row_wrap();
    for (int n = 2; n < 160; n++) begin
      serve_pixel(n, 1'b0, 0, int'($urandom_range(1, 4)), -1);
    end
    checks++;
    if (bus.eng_valid !== 1'b1 || bus.vga_x !== 8'd0 || bus.vga_y !== 7'd1 ||
        bus.eng_cr !== 16'(-8192) || bus.eng_ci !== 16'(4028)) begin
      errors++;
      $display("FAIL row_wrap: valid=%b x=%0d y=%0d cr=%0d ci=%0d, want 1 0 1 -8192 4028",
               bus.eng_valid, bus.vga_x, bus.vga_y, bus.eng_cr, bus.eng_ci);
    end
  endtask

  task automatic test_full_frame();
    int exp_plots;
    for (int n = 160; n < NPIX; n++) begin
      serve_pixel(n, 1'b1, 0, 1, (n == 160) ? -1 : 255);
    end
`ifdef MDBROT_CLEAR_EN
    exp_plots = 2 * NPIX;
`else
    exp_plots = NPIX;
`endif
    checks++;
    if (plot_cnt - frame_plot_base !== exp_plots) begin
      errors++;
      $display("FAIL plot_count: got %0d, want %0d", plot_cnt - frame_plot_base, exp_plots);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.done !== 1'b1 || bus.eng_valid !== 1'b0 || bus.vga_plot !== 1'b0) begin
        errors++;
        $display("FAIL done_hold[%0d]: done=%b valid=%b plot=%b, want 1 0 0",
                 i, bus.done, bus.eng_valid, bus.vga_plot);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    checks++;
`ifdef MDBROT_CLEAR_EN
    if (bus.done !== 1'b0 || bus.vga_plot !== 1'b1 || bus.vga_x !== 8'd0 ||
        bus.vga_y !== 7'd0 || bus.vga_colour !== 3'b000) begin
      errors++;
      $display("FAIL restart: done=%b plot=%b x=%0d y=%0d colour=%0d, want 0 1 0 0 0",
               bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
`else
    if (bus.done !== 1'b0 || bus.eng_valid !== 1'b1 || bus.vga_x !== 8'd0 ||
        bus.vga_y !== 7'd0 || bus.eng_cr !== 16'(CR_START) || bus.eng_ci !== 16'(CI_START)) begin
      errors++;
      $display("FAIL restart: done=%b valid=%b x=%0d y=%0d cr=%0d ci=%0d, want 0 1 0 0 %0d %0d",
               bus.done, bus.eng_valid, bus.vga_x, bus.vga_y, bus.eng_cr, bus.eng_ci,
               CR_START, CI_START);
    end
`endif
  endtask

  task automatic test_mid_reset();
`ifdef MDBROT_CLEAR_EN
    check_clear(500);
`else
    for (int n = 0; n < 500; n++) begin
      serve_pixel(n, 1'b1, 0, 1, -1);
    end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.done, bus.eng_valid, bus.eng_cr, bus.eng_ci, bus.vga_x, bus.vga_y,
         bus.vga_colour, bus.vga_plot} !== 53'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h, want 0", {bus.done, bus.eng_valid, bus.eng_cr,
               bus.eng_ci, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.done, bus.eng_valid, bus.eng_cr, bus.eng_ci, bus.vga_x, bus.vga_y,
           bus.vga_colour, bus.vga_plot} !== 53'd0) begin
        errors++;
        $display("FAIL mid_reset_idle[%0d]: got %h, want 0", i, {bus.done, bus.eng_valid,
                 bus.eng_cr, bus.eng_ci, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.eng_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_iter  = 8'd0;
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_row_wrap();
    test_full_frame();
    test_restart();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
